// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one bit per clock.
// Operands enter through an in_valid/in_ready handshake and the result
// leaves through an out_valid/out_ready handshake.
// Optional build macro SERIAL_ADDER_CIN_EN adds a carry-in port (cin)
// that is sampled with a/b and used as the initial carry.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Full-adder sum bit: two cascaded half adders.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry: majority of the three inputs.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             bit_s, cout_s, cin_init_s;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin_init_s = cin;
`else
  assign cin_init_s = 1'b0;
`endif

  // Sequencing: next state, shift/accumulate datapath and result capture.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    bit_s   = fa_sum(a_sh_q[0], b_sh_q[0], c_q);
    cout_s  = fa_carry(a_sh_q[0], b_sh_q[0], c_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          psum_d  = '0;
          c_d     = cin_init_s;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        psum_d = {bit_s, psum_q[WIDTH-1:1]};
        c_d    = cout_s;
        if (cnt_q == LAST_CNT) begin
          // Last bit: publish the completed sum and the MSB carry-out.
          state_d = DONE;
          sum_d   = {bit_s, psum_q[WIDTH-1:1]};
          carry_d = cout_s;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      psum_q      <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      psum_q      <= psum_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH = 8).
// Define SERIAL_ADDER_CIN_EN for both files to exercise the carry-in port.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk_s = 1'b0;
  logic         rst_s;
  logic         in_valid_s;
  logic         in_ready_s;
  logic [W-1:0] a_s, b_s;
  logic         cin_s;
  logic         out_valid_s;
  logic         out_ready_s;
  logic [W-1:0] sum_s;
  logic         carry_s;
  logic         busy_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk_s),
    .rst       (rst_s),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .a         (a_s),
    .b         (b_s),
`ifdef SERIAL_ADDER_CIN_EN
    .cin       (cin_s),
`endif
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .sum       (sum_s),
    .carry     (carry_s),
    .busy      (busy_s)
  );

  always #5 clk_s = ~clk_s;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_s);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete add with out_ready held high; checks latency and result.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic [W-1:0] es,
                         input logic ec, input string tag);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready_s && guard < 30) begin
      step();
      guard++;
    end
    chk({tag, "_ready_before"}, {31'd0, in_ready_s}, 32'd1);
    a_s = av; b_s = bv; cin_s = ci;
    in_valid_s  = 1'b1;
    out_ready_s = 1'b1;
    step();
    in_valid_s = 1'b0;
    a_s = ~av; b_s = ~bv; cin_s = ~ci;
    lat = 0;
    while (!out_valid_s && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_sum"}, {24'd0, sum_s}, {24'd0, es});
    chk({tag, "_carry"}, {31'd0, carry_s}, {31'd0, ec});
    step();
    chk({tag, "_ovalid_drop"}, {31'd0, out_valid_s}, 32'd0);
    chk({tag, "_iready_back"}, {31'd0, in_ready_s}, 32'd1);
  endtask

  logic [W-1:0] bb_a   [4] = '{8'hA7, 8'h33, 8'hF0, 8'hC8};
  logic [W-1:0] bb_b   [4] = '{8'h6B, 8'h44, 8'h0F, 8'h9D};
  logic [W-1:0] bb_sum [4] = '{8'h12, 8'h77, 8'hFF, 8'h65};
  logic         bb_c   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int guard;
    int acc_t;
    int prev_acc;
    rst_s = 1'b1; in_valid_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0;
    out_ready_s = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready_s},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
    chk("rst_sum",       {24'd0, sum_s},       32'd0);
    chk("rst_carry",     {31'd0, carry_s},     32'd0);
    chk("rst_busy",      {31'd0, busy_s},      32'd0);
    step(); step();
    rst_s = 1'b0;
    step();

    // Basic and carry-propagation adds.
    run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01");
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80_80");

    // Backpressure plus in_valid asserted during RUN and DONE.
    a_s = 8'h77; b_s = 8'h99; in_valid_s = 1'b1; out_ready_s = 1'b0;
    step();
    chk("bp_busy", {31'd0, busy_s}, 32'd1);
    a_s = 8'h01; b_s = 8'h01;
    guard = 0;
    while (!out_valid_s && guard < 20) begin
      chk("bp_run_in_ready", {31'd0, in_ready_s}, 32'd0);
      step();
      guard++;
    end
    chk("bp_latency", guard, W);
    for (int i = 0; i < 5; i++) begin
      a_s = 8'(i * 17); b_s = 8'(i * 3 + 1);
      chk("bp_hold_valid", {31'd0, out_valid_s}, 32'd1);
      chk("bp_hold_sum",   {24'd0, sum_s},       32'h10);
      chk("bp_hold_carry", {31'd0, carry_s},     32'd1);
      chk("bp_hold_ready", {31'd0, in_ready_s},  32'd0);
      step();
    end
    out_ready_s = 1'b1; in_valid_s = 1'b0;
    step();
    chk("bp_release_valid", {31'd0, out_valid_s}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready_s},  32'd1);
    chk("bp_sum_kept",      {24'd0, sum_s},       32'h10);
    step();
    chk("bp_no_restart",    {31'd0, busy_s},      32'd0);

    // Reset three cycles into a run.
    a_s = 8'h12; b_s = 8'h34; in_valid_s = 1'b1;
    step();
    in_valid_s = 1'b0;
    step(); step(); step();
    rst_s = 1'b1;
    #2;
    chk("mid_rst_out_valid", {31'd0, out_valid_s}, 32'd0);
    chk("mid_rst_sum",       {24'd0, sum_s},       32'd0);
    chk("mid_rst_carry",     {31'd0, carry_s},     32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready_s},  32'd1);
    chk("mid_rst_busy",      {31'd0, busy_s},      32'd0);
    rst_s = 1'b0;
    step();
    run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_rst");

    // Back-to-back with in_valid and out_ready held high.
    out_ready_s = 1'b1;
    in_valid_s  = 1'b1;
    prev_acc = 0;
    for (int j = 0; j < 4; j++) begin
      a_s = bb_a[j]; b_s = bb_b[j];
      guard = 0;
      while (!in_ready_s && guard < 30) begin
        step();
        guard++;
      end
      step();
      acc_t = cyc;
      if (j > 0) chk("b2b_spacing", acc_t - prev_acc, W + 2);
      prev_acc = acc_t;
      guard = 0;
      while (!out_valid_s && guard < 20) begin
        step();
        guard++;
      end
      chk("b2b_latency", guard, W);
      chk("b2b_sum",   {24'd0, sum_s},   {24'd0, bb_sum[j]});
      chk("b2b_carry", {31'd0, carry_s}, {31'd0, bb_c[j]});
    end
    in_valid_s = 1'b0;
    step();
    step();

`ifdef SERIAL_ADDER_CIN_EN
    run_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "cin_ff");
    run_add(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, "cin_10_20");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial unsigned adder: accepts two WIDTH-bit operands through a valid/ready handshake, adds them LSB-first, one bit per clock, with a single carry flip-flop, and returns the WIDTH-bit sum plus carry-out through a second valid/ready handshake.
- Per-bit datapath is a half-adder pair plus an OR (sum = a^b^c, carry = majority); the block wraps that combinational cell in sequencing logic.
- Area-optimised alternative to a ripple adder of WIDTH full-adder cells. Sits between an operand source and any consumer of sum/carry.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A, sampled on input handshake
- b  input  WIDTH  operand B, sampled on input handshake
- out_valid  output  1  sum/carry valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result, a+b mod 2^WIDTH
- carry  output  1  registered carry-out of MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- State machine states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values:
  - in_ready = 1 (IDLE), out_valid = 0, sum = 0, carry = 0, busy = 0.
  - Internal operand shift registers, carry flip-flop and bit counter = 0.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1: load a and b into shift registers, clear the carry flip-flop, clear the counter, go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge: bit s = a_sh[0] ^ b_sh[0] ^ c; c <= (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])).
  - Each edge: shift both operand registers right by 1; shift s into the MSB of the partial-sum register; increment the counter.
  - When the counter reaches WIDTH-1 on an edge, that edge processes the last bit, copies the final partial sum into sum and the final carry into carry, and goes to DONE.
- Latency: if operands are accepted at edge k, out_valid is first high after edge k+WIDTH (exactly WIDTH cycles).
- DONE:
  - out_valid = 1, in_ready = 0.
  - sum and carry are held stable until the output handshake.
  - On an edge with out_ready = 1: go to IDLE and drop out_valid.
- The next operand pair can be accepted no earlier than the edge after the output handshake. Minimum throughput: one add per WIDTH+2 cycles.
- in_valid is ignored outside IDLE. a/b may change freely after acceptance without affecting the result.
- sum/carry change only on the RUN->DONE transition or on reset. They keep the last result in IDLE.
- out_ready is ignored outside DONE.
- busy = (state != IDLE).
- Reset mid-operation: asynchronous return to IDLE with all reset values. The in-flight addition is discarded and no out_valid is produced for it.
- Width rules:
  - Counter width is clog2(WIDTH).
  - No arithmetic wraps except the sum itself, which is mod 2^WIDTH with overflow reported only on carry.

Optional Feature:
- Macro: SERIAL_ADDER_CIN_EN.
- Defined: adds input port cin (1 bit), sampled with a/b on the input handshake and loaded as the initial carry. Result = a+b+cin; carry is the carry-out of that sum.
- Undefined: no cin port; initial carry is always 0.

Test Plan:
- Basic add, WIDTH=8: a=0x5A, b=0x3C, in_valid pulse, out_ready=1 -> out_valid exactly 8 cycles after acceptance, sum=0x96, carry=0; then in_ready=1 the following cycle.
- Carry propagation: a=0xFF, b=0x01 -> sum=0x00, carry=1. Also a=0x80, b=0x80 -> sum=0x00, carry=1.
- Backpressure and ignored inputs:
  - Hold out_ready=0 for 5 cycles after out_valid -> sum/carry/out_valid stable for all 5 cycles; single handshake on release.
  - Drive in_valid=1 with new a/b during RUN and DONE -> ignored; in_ready=0 throughout.
- Reset mid-RUN: assert rst 3 cycles after accepting 0x12+0x34 -> out_valid=0, sum=0, carry=0, in_ready=1 immediately. A subsequent 0x01+0x02 yields 0x03 with normal latency.
- Back-to-back: keep in_valid=1 and out_ready=1 across 4 random operand pairs -> each result matches the reference a+b; accepts spaced WIDTH+2 cycles.
- With SERIAL_ADDER_CIN_EN: a=0xFF, b=0x00, cin=1 -> sum=0x00, carry=1. a=0x10, b=0x20, cin=1 -> sum=0x31, carry=0.
